// File: rtl/delta_pkg.sv
// Shared types and helpers for the delta encoder.
//   state_t     : encoder frame state (IDLE, RUN, DRAIN)
//   DELTA_MIN/MAX, delta_t, act_t : code range and element types at default widths
//   saturate()  : clamp a signed value to the range of a given bit width
package delta_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int DELTA_WIDTH_DFLT = 3;
  localparam int FULL_WIDTH_DFLT  = 16;

  localparam int DELTA_MIN = -(2 ** (DELTA_WIDTH_DFLT - 1));
  localparam int DELTA_MAX = (2 ** (DELTA_WIDTH_DFLT - 1)) - 1;

  typedef logic signed [DELTA_WIDTH_DFLT-1:0] delta_t;
  typedef logic signed [FULL_WIDTH_DFLT-1:0]  act_t;

  function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                  input int unsigned        width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi)      saturate = hi;
    else if (v < lo) saturate = lo;
    else             saturate = v;
  endfunction

endpackage

// File: rtl/delta_quantizer.sv
// Combinational delta quantiser for one element.
//   x, prev    : current and previous activation (signed FULL_WIDTH)
//   budget_ok  : an outlier slot is still available in this group
//   code       : signed DELTA_WIDTH delta code
//   outlier    : element is carried full-width on the outlier channel
//   new_prev   : reconstructed value to store for the next timestep
//   ol_value   : difference saturated to FULL_WIDTH (outlier payload)
module delta_quantizer
  import delta_pkg::*;
#(
  parameter int DELTA_WIDTH = 3,
  parameter int FULL_WIDTH  = 16,
  parameter int SHIFT       = 4
) (
  input  logic [FULL_WIDTH-1:0]  x,
  input  logic [FULL_WIDTH-1:0]  prev,
  input  logic                   budget_ok,
  output logic [DELTA_WIDTH-1:0] code,
  output logic                   outlier,
  output logic [FULL_WIDTH-1:0]  new_prev,
  output logic [FULL_WIDTH-1:0]  ol_value
);

  localparam int QMAX = (1 << (DELTA_WIDTH - 1)) - 1;
  localparam int QMIN = -QMAX - 1;

  logic signed [FULL_WIDTH:0] d;
  logic signed [FULL_WIDTH:0] q;
  logic signed [31:0]         q32;
  logic signed [31:0]         qc32;
  logic signed [31:0]         prev32;
  logic                       in_range;

  always_comb begin
    d        = $signed({x[FULL_WIDTH-1], x}) - $signed({prev[FULL_WIDTH-1], prev});
    q        = d >>> SHIFT;
    q32      = 32'(q);
    prev32   = 32'($signed(prev));
    in_range = (q32 >= QMIN) && (q32 <= QMAX);
    // Out-of-range values that cannot use the outlier channel are clamped
    // to the nearest code and reconstructed from that clamped code.
    qc32     = in_range ? q32 : ((q32 < 0) ? QMIN : QMAX);
    ol_value = FULL_WIDTH'(saturate(32'(d), FULL_WIDTH));
    if (in_range || !budget_ok) begin
      outlier  = 1'b0;
      code     = DELTA_WIDTH'(qc32);
      new_prev = FULL_WIDTH'(saturate(prev32 + (qc32 <<< SHIFT), FULL_WIDTH));
    end else begin
      outlier  = 1'b1;
      code     = '0;
      new_prev = x;
    end
  end

endmodule

// File: rtl/delta_encoder.sv
// Temporal delta encoder: subtracts the previous timestep's reconstructed
// activations, quantises the difference and routes large differences to a
// full-width outlier channel (limited per group).
//   start/first_step          : frame start (IDLE only), treat prev as zero
//   in_valid/in_ready/in_data : activation stream
//   out_*                     : delta code stream (registered)
//   ol_*                      : outlier records (registered)
//   busy/done                 : frame in progress / final output accepted
module delta_encoder
  import delta_pkg::*;
#(
  parameter int VEC_LEN                = 1024,
  parameter int GROUP_SIZE             = 32,
  parameter int MAX_OUTLIERS_PER_GROUP = 2,
  parameter int DELTA_WIDTH            = 3,
  parameter int FULL_WIDTH             = 16,
  parameter int SHIFT                  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       first_step,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FULL_WIDTH-1:0]      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DELTA_WIDTH-1:0]     out_delta,
  output logic                       out_sign,
  output logic                       out_outlier,
  output logic                       out_group_last,
  output logic                       ol_valid,
  input  logic                       ol_ready,
  output logic [$clog2(VEC_LEN)-1:0] ol_index,
  output logic [FULL_WIDTH-1:0]      ol_value,
  output logic                       busy,
  output logic                       done
);

  localparam int IDX_W = $clog2(VEC_LEN);
  localparam int GRP_W = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;
  localparam int OLC_W = $clog2(MAX_OUTLIERS_PER_GROUP + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(GROUP_SIZE - 1);
  localparam logic [OLC_W-1:0] OL_MAX   = OLC_W'(MAX_OUTLIERS_PER_GROUP);

  state_t state_q, state_d;

  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [GRP_W-1:0]       grp_cnt_q, grp_cnt_d;
  logic [OLC_W-1:0]       ol_cnt_q, ol_cnt_d;
  logic                   first_q, first_d;
  logic                   prev_valid_q, prev_valid_d;

  logic                   out_valid_q, out_valid_d;
  logic [DELTA_WIDTH-1:0] out_delta_q, out_delta_d;
  logic                   out_sign_q, out_sign_d;
  logic                   out_outlier_q, out_outlier_d;
  logic                   out_glast_q, out_glast_d;
  logic                   ol_valid_q, ol_valid_d;
  logic [IDX_W-1:0]       ol_index_q, ol_index_d;
  logic [FULL_WIDTH-1:0]  ol_value_q, ol_value_d;

  logic [FULL_WIDTH-1:0]  prev_mem [VEC_LEN];

  logic                   slots_free;
  logic                   accept;
  logic                   group_last;
  logic [FULL_WIDTH-1:0]  prev_rd;
  logic [DELTA_WIDTH-1:0] q_code;
  logic                   q_outlier;
  logic [FULL_WIDTH-1:0]  q_new_prev;
  logic [FULL_WIDTH-1:0]  q_ol_value;

  // Both output slots free (or being drained this cycle).
  assign slots_free = (!out_valid_q || out_ready) && (!ol_valid_q || ol_ready);
  assign accept     = in_valid && in_ready;
  assign group_last = (grp_cnt_q == LAST_GRP) || (idx_q == LAST_IDX);
  assign prev_rd    = first_q ? '0 : prev_mem[idx_q];

  delta_quantizer #(
    .DELTA_WIDTH (DELTA_WIDTH),
    .FULL_WIDTH  (FULL_WIDTH),
    .SHIFT       (SHIFT)
  ) u_quant (
    .x         (in_data),
    .prev      (prev_rd),
    .budget_ok (ol_cnt_q < OL_MAX),
    .code      (q_code),
    .outlier   (q_outlier),
    .new_prev  (q_new_prev),
    .ol_value  (q_ol_value)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && (idx_q == LAST_IDX)) state_d = DRAIN;
      DRAIN:   if (slots_free) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q == RUN) && slots_free;
    busy     = (state_q != IDLE);
    done     = (state_q == DRAIN) && slots_free;
  end

  // Counters, flags and output registers
  always_comb begin
    idx_d         = idx_q;
    grp_cnt_d     = grp_cnt_q;
    ol_cnt_d      = ol_cnt_q;
    first_d       = first_q;
    prev_valid_d  = prev_valid_q;
    out_delta_d   = out_delta_q;
    out_sign_d    = out_sign_q;
    out_outlier_d = out_outlier_q;
    out_glast_d   = out_glast_q;
    ol_index_d    = ol_index_q;
    ol_value_d    = ol_value_q;
    out_valid_d   = out_valid_q && !out_ready;
    ol_valid_d    = ol_valid_q && !ol_ready;

    if ((state_q == IDLE) && start) begin
      idx_d     = '0;
      grp_cnt_d = '0;
      ol_cnt_d  = '0;
      first_d   = first_step || !prev_valid_q;
    end

    if (accept) begin
      idx_d         = idx_q + IDX_W'(1);
      grp_cnt_d     = group_last ? '0 : grp_cnt_q + GRP_W'(1);
      ol_cnt_d      = group_last ? '0 : ol_cnt_q + OLC_W'(q_outlier);
      out_valid_d   = 1'b1;
      out_delta_d   = q_code;
      out_sign_d    = ~in_data[FULL_WIDTH-1];
      out_outlier_d = q_outlier;
      out_glast_d   = group_last;
      if (q_outlier) begin
        ol_valid_d = 1'b1;
        ol_index_d = idx_q;
        ol_value_d = q_ol_value;
      end
    end

    if ((state_q == DRAIN) && slots_free) prev_valid_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q         <= '0;
      grp_cnt_q     <= '0;
      ol_cnt_q      <= '0;
      first_q       <= 1'b0;
      prev_valid_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      out_delta_q   <= '0;
      out_sign_q    <= 1'b0;
      out_outlier_q <= 1'b0;
      out_glast_q   <= 1'b0;
      ol_valid_q    <= 1'b0;
      ol_index_q    <= '0;
      ol_value_q    <= '0;
    end else begin
      idx_q         <= idx_d;
      grp_cnt_q     <= grp_cnt_d;
      ol_cnt_q      <= ol_cnt_d;
      first_q       <= first_d;
      prev_valid_q  <= prev_valid_d;
      out_valid_q   <= out_valid_d;
      out_delta_q   <= out_delta_d;
      out_sign_q    <= out_sign_d;
      out_outlier_q <= out_outlier_d;
      out_glast_q   <= out_glast_d;
      ol_valid_q    <= ol_valid_d;
      ol_index_q    <= ol_index_d;
      ol_value_q    <= ol_value_d;
    end
  end

  // Previous-activation store has no reset; prev_valid guards stale data.
  always_ff @(posedge clk) begin
    if (accept) prev_mem[idx_q] <= q_new_prev;
  end

  assign out_valid      = out_valid_q;
  assign out_delta      = out_delta_q;
  assign out_sign       = out_sign_q;
  assign out_outlier    = out_outlier_q;
  assign out_group_last = out_glast_q;
  assign ol_valid       = ol_valid_q;
  assign ol_index       = ol_index_q;
  assign ol_value       = ol_value_q;

endmodule
